// File: rtl/iir_coeff_loader.sv
// Host-side coefficient loader for the biquad notch filter: shadow registers, denominator
// stability check, gap-aligned single-cycle parallel write and readback verification.
module iir_coeff_loader #(
  parameter int unsigned COEFF_WIDTH = 20,
  parameter int unsigned COEFF_FRAC  = 18,
  parameter int unsigned COEFF_DEPTH = 5,
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned GAP_TIMEOUT = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [ADDR_WIDTH-1:0]              cfg_addr,
  input  logic [COEFF_WIDTH-1:0]             cfg_data,
  input  logic                               cfg_commit,
  input  logic                               sample_valid,
  output logic                               coeff_wr_en,
  output logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_in,
  input  logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_rb,
  output logic                               busy,
  output logic                               done,
  output logic                               err_addr,
  output logic                               err_incomplete,
  output logic                               err_unstable,
  output logic                               err_verify,
  output logic                               forced
);

  localparam int unsigned ExtW  = COEFF_WIDTH + 2;
  localparam int unsigned CntW  = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
  localparam int unsigned IdxA1 = 3;
  localparam int unsigned IdxA2 = 4;

  localparam logic signed [ExtW-1:0] One     = ExtW'(1) << COEFF_FRAC;
  localparam logic        [CntW-1:0] CntLast = CntW'(GAP_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StCheck, StWaitGap, StVerify} state_e;

  state_e                        state_q;
  logic signed [COEFF_WIDTH-1:0] shadow_q [COEFF_DEPTH];
  logic [COEFF_DEPTH-1:0]        mask_q;
  logic [CntW-1:0]               cnt_q;
  logic                          done_q;
  logic                          err_addr_q;
  logic                          err_incomplete_q;
  logic                          err_unstable_q;
  logic                          err_verify_q;
  logic                          forced_q;

  logic                          addr_ok;
  logic                          mask_full;
  logic                          stable;
  logic                          mismatch;
  logic signed [ExtW-1:0]        a1_ext;
  logic signed [ExtW-1:0]        a2_ext;
  logic signed [ExtW-1:0]        a1_abs;

  assign addr_ok   = (32'(cfg_addr) < COEFF_DEPTH);
  assign mask_full = &mask_q;

  // Two guard bits keep |a1| and ONE + a2 exact even at the most negative a1.
  always_comb begin
    a1_ext = {{2{shadow_q[IdxA1][COEFF_WIDTH-1]}}, shadow_q[IdxA1]};
    a2_ext = {{2{shadow_q[IdxA2][COEFF_WIDTH-1]}}, shadow_q[IdxA2]};
    a1_abs = a1_ext[ExtW-1] ? -a1_ext : a1_ext;
    stable = (a2_ext > -One) && (a2_ext < One) && (a1_abs < (One + a2_ext));
  end

  always_comb begin
    coeff_in = '0;
    mismatch = 1'b0;
    for (int unsigned i = 0; i < COEFF_DEPTH; i++) begin
      coeff_in[i*COEFF_WIDTH +: COEFF_WIDTH] = shadow_q[i];
      mismatch = mismatch | (coeff_rb[i*COEFF_WIDTH +: COEFF_WIDTH] != shadow_q[i]);
    end
  end

  assign coeff_wr_en = (state_q == StWaitGap) && (!sample_valid || (cnt_q == CntLast));
  assign cfg_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign err_addr       = err_addr_q;
  assign err_incomplete = err_incomplete_q;
  assign err_unstable   = err_unstable_q;
  // The readback result is visible in the same cycle as the done pulse and held afterwards.
  assign err_verify     = err_verify_q | ((state_q == StVerify) && mismatch);
  assign forced         = forced_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      for (int unsigned i = 0; i < COEFF_DEPTH; i++) begin
        shadow_q[i] <= '0;
      end
      mask_q           <= '0;
      cnt_q            <= '0;
      done_q           <= 1'b0;
      err_addr_q       <= 1'b0;
      err_incomplete_q <= 1'b0;
      err_unstable_q   <= 1'b0;
      err_verify_q     <= 1'b0;
      forced_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_valid) begin
            if (addr_ok) begin
              shadow_q[cfg_addr] <= cfg_data;
              mask_q[cfg_addr]   <= 1'b1;
            end else begin
              err_addr_q <= 1'b1;
            end
          end
          if (cfg_commit) begin
            err_incomplete_q <= 1'b0;
            err_unstable_q   <= 1'b0;
            err_verify_q     <= 1'b0;
            forced_q         <= 1'b0;
            state_q          <= StCheck;
          end
        end
        StCheck: begin
          if (!mask_full) begin
            err_incomplete_q <= 1'b1;
            done_q           <= 1'b1;
            state_q          <= StIdle;
          end else if (!stable) begin
            err_unstable_q <= 1'b1;
            done_q         <= 1'b1;
            state_q        <= StIdle;
          end else begin
            cnt_q   <= '0;
            state_q <= StWaitGap;
          end
        end
        StWaitGap: begin
          if (coeff_wr_en) begin
            forced_q <= sample_valid;
            done_q   <= 1'b1;
            state_q  <= StVerify;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StVerify: begin
          if (mismatch) begin
            err_verify_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader with a behavioural filter coefficient port model.
module tb_iir_coeff_loader;

  localparam int unsigned W = 20;
  localparam int unsigned D = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [2:0]     cfg_addr;
  logic [W-1:0]   cfg_data;
  logic           cfg_commit;
  logic           sample_valid;
  logic           coeff_wr_en;
  logic [W*D-1:0] coeff_in;
  logic [W*D-1:0] coeff_rb;
  logic           busy;
  logic           done;
  logic           err_addr;
  logic           err_incomplete;
  logic           err_unstable;
  logic           err_verify;
  logic           forced;

  iir_coeff_loader #(
    .COEFF_WIDTH(W),
    .COEFF_FRAC (18),
    .COEFF_DEPTH(D),
    .ADDR_WIDTH (3),
    .GAP_TIMEOUT(64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_commit    (cfg_commit),
    .sample_valid  (sample_valid),
    .coeff_wr_en   (coeff_wr_en),
    .coeff_in      (coeff_in),
    .coeff_rb      (coeff_rb),
    .busy          (busy),
    .done          (done),
    .err_addr      (err_addr),
    .err_incomplete(err_incomplete),
    .err_unstable  (err_unstable),
    .err_verify    (err_verify),
    .forced        (forced)
  );

  always #5 clk = ~clk;

  // Filter model: captures coeff_in on a write; corrupt flips bits of a1 on readback.
  logic [W*D-1:0] rb_q = '0;
  logic           corrupt = 1'b0;
  int             wr_total = 0;
  always @(posedge clk) begin
    if (coeff_wr_en) begin
      rb_q     <= coeff_in;
      wr_total <= wr_total + 1;
    end
  end
  assign coeff_rb = corrupt ? (rb_q ^ ({{(W*D-W){1'b0}}, 20'h00001} << (3*W))) : rb_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] addr, input logic [W-1:0] data);
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_data  = data;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // Commit cycle is N; k counts cycles after N. drop_at > 0 lowers sample_valid from N+drop_at.
  task automatic commit_run(input logic sv_hold, input int drop_at, output int wr_first,
                            output int wr_cnt, output int done_at, output logic [W*D-1:0] wr_word);
    wr_first = -1;
    wr_cnt   = 0;
    done_at  = -1;
    wr_word  = '0;
    @(posedge clk); #1;
    cfg_commit = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk); #1;
      cfg_commit   = 1'b0;
      cfg_valid    = 1'b0;
      sample_valid = sv_hold && !(drop_at > 0 && k >= drop_at);
      @(negedge clk);
      if (coeff_wr_en) begin
        if (wr_first < 0) begin
          wr_first = k;
          wr_word  = coeff_in;
        end
        wr_cnt++;
      end
      if (done && done_at < 0) done_at = k;
      if (done_at >= 0 && k > done_at) break;
    end
    if (done_at < 0) chk("commit_done_timeout", 0, 1);
    sample_valid = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a1;
    logic [W-1:0] a2;
    logic         unstable;
  } stab_vec_t;

  stab_vec_t      vecs[9];
  int             wf, wc, da;
  logic [W*D-1:0] ww;
  logic [W*D-1:0] exp_vec;
  int             wr_before;

  initial begin
    vecs[0] = '{a1: 20'h5907C, a2: 20'h40000, unstable: 1'b1}; // a2 == 1.0
    vecs[1] = '{a1: 20'h70000, a2: 20'h2E0C3, unstable: 1'b1}; // 458752 > 450755
    vecs[2] = '{a1: 20'h5907C, a2: 20'h2E0C3, unstable: 1'b0};
    vecs[3] = '{a1: 20'h6E0C2, a2: 20'h2E0C3, unstable: 1'b0}; // |a1| = ONE+a2-1
    vecs[4] = '{a1: 20'h6E0C3, a2: 20'h2E0C3, unstable: 1'b1}; // |a1| == ONE+a2
    vecs[5] = '{a1: 20'h00000, a2: 20'hC0000, unstable: 1'b1}; // a2 == -1.0
    vecs[6] = '{a1: 20'h00000, a2: 20'hC0001, unstable: 1'b0}; // a2 just above -1.0
    vecs[7] = '{a1: 20'h80000, a2: 20'h2E0C3, unstable: 1'b1}; // most negative a1
    vecs[8] = '{a1: 20'hA6F84, a2: 20'h2E0C3, unstable: 1'b0}; // a1 = -0x5907C

    rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_commit = 1'b0; sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", coeff_wr_en, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_errs", {err_addr, err_incomplete, err_unstable, err_verify, forced}, 0);
    chk("rst_coeff_in", coeff_in, 0);

    commit_run(1'b0, 0, wf, wc, da, ww);
    chk("incomplete_done_at", da, 2);
    chk("incomplete_no_wr", wc, 0);
    chk("incomplete_flag", err_incomplete, 1);

    wr(3'd0, 20'h37061); wr(3'd1, 20'h5907C); wr(3'd2, 20'h37061);
    wr(3'd3, 20'h5907C); wr(3'd4, 20'h2E0C3);
    exp_vec = {20'h2E0C3, 20'h5907C, 20'h37061, 20'h5907C, 20'h37061};
    chk("load_coeff_in", coeff_in, exp_vec);
    commit_run(1'b0, 0, wf, wc, da, ww);
    chk("load_wr_at", wf, 2);
    chk("load_wr_cnt", wc, 1);
    chk("load_done_at", da, 3);
    chk("load_wr_word", ww, exp_vec);
    chk("load_errs", {err_incomplete, err_unstable, err_verify, forced}, 0);

    for (int i = 0; i < 9; i++) begin
      wr(3'd3, vecs[i].a1);
      wr(3'd4, vecs[i].a2);
      commit_run(1'b0, 0, wf, wc, da, ww);
      chk($sformatf("stab%0d_unstable", i), err_unstable, vecs[i].unstable);
      chk($sformatf("stab%0d_wr_cnt", i), wc, vecs[i].unstable ? 0 : 1);
      chk($sformatf("stab%0d_done_at", i), da, vecs[i].unstable ? 2 : 3);
    end

    wr(3'd3, 20'h5907C);
    wr(3'd4, 20'h2E0C3);
    commit_run(1'b1, 0, wf, wc, da, ww);
    chk("timeout_wr_at", wf, 65);
    chk("timeout_wr_cnt", wc, 1);
    chk("timeout_done_at", da, 66);
    chk("timeout_forced", forced, 1);
    commit_run(1'b1, 10, wf, wc, da, ww);
    chk("gap_wr_at", wf, 10);
    chk("gap_done_at", da, 11);
    chk("gap_forced", forced, 0);

    wr(3'd6, 20'h12345);
    chk("bad_addr_flag", err_addr, 1);
    chk("bad_addr_shadow", coeff_in, exp_vec);

    corrupt = 1'b1;
    commit_run(1'b0, 0, wf, wc, da, ww);
    chk("verify_err", err_verify, 1);
    corrupt = 1'b0;
    commit_run(1'b0, 0, wf, wc, da, ww);
    chk("verify_clean", err_verify, 0);

    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_addr = 3'd4; cfg_data = 20'h2E0C4;
    commit_run(1'b0, 0, wf, wc, da, ww);
    chk("same_cycle_wr_at", wf, 2);
    chk("same_cycle_a2", ww[4*W +: W], 20'h2E0C4);

    // Write while busy is ignored, then reset aborts a pending write.
    @(posedge clk); #1;
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0; sample_valid = 1'b1;
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 20'h11111;
    @(negedge clk);
    chk("busy_ready", cfg_ready, 0);
    chk("busy_flag", busy, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("busy_write_ignored", coeff_in[W-1:0], 20'h37061);
    wr_before = wr_total;
    sample_valid = 1'b0;
    #1;
    chk("pre_rst_wr_en", coeff_wr_en, 1);
    rst = 1'b1;
    #1;
    chk("rst_kills_wr_en", coeff_wr_en, 0);
    @(posedge clk); #1;
    chk("rst_no_write", wr_total, wr_before);
    chk("rst_coeff_cleared", coeff_in, 0);
    rst = 1'b0;
    commit_run(1'b0, 0, wf, wc, da, ww);
    chk("post_rst_incomplete", err_incomplete, 1);
    chk("post_rst_no_wr", wc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_coeff_loader.md
Name: iir_coeff_loader

Overview:
- Host-side writer for the biquad notch filter's parallel coefficient port. It drives coeff_wr_en/coeff_in and reads back coeff_out.
- The host writes the five coefficients one word at a time into shadow registers. A commit request then triggers a stability check on the denominator coefficients.
- If the check passes, the block issues a single-cycle parallel write into the filter during a gap in the sample stream. It then verifies the readback.
- Sits between the register/config bus and the filter instance.

Parameters:
- COEFF_WIDTH, 20: coefficient word width, signed.
- COEFF_FRAC, 18: fractional bits. Fixed-point 1.0 = 2^COEFF_FRAC.
- COEFF_DEPTH, 5: number of coefficients. Index order is b0, b1, b2, a1, a2.
- ADDR_WIDTH, 3: width of cfg_addr.
- GAP_TIMEOUT, 64: maximum cycles to wait for a sample gap before forcing the write.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  host coefficient write strobe.
- cfg_ready  out  1  loader can accept a write or commit.
- cfg_addr  in  ADDR_WIDTH  coefficient index, 0..4.
- cfg_data  in  COEFF_WIDTH  signed coefficient value.
- cfg_commit  in  1  request to push shadow registers to the filter.
- sample_valid  in  1  copy of the filter's valid_in; used to find a sample gap.
- coeff_wr_en  out  1  filter coefficient write enable.
- coeff_in  out  COEFF_WIDTH x COEFF_DEPTH  shadow coefficients; drives the filter's coeff_in.
- coeff_rb  in  COEFF_WIDTH x COEFF_DEPTH  filter's coeff_out.
- busy  out  1  commit in progress.
- done  out  1  one-cycle pulse at the end of every commit.
- err_addr  out  1  sticky: a write to an address >= COEFF_DEPTH was attempted.
- err_incomplete  out  1  commit rejected because not all coefficients have been written since reset.
- err_unstable  out  1  commit rejected by the stability check.
- err_verify  out  1  readback mismatch after a write.
- forced  out  1  write was issued after GAP_TIMEOUT expired.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; shadow registers and write mask=0.
  - coeff_wr_en=0, busy=0, done=0, all error/forced flags=0; cfg_ready=1 once rst deasserts.
  - Reset mid-commit aborts the commit immediately; no write occurs after rst rises.
- States: IDLE, CHECK, WAIT_GAP, VERIFY.
- cfg_ready=1 only in IDLE. busy = (state != IDLE).
- IDLE, write accept:
  - A write is accepted when cfg_valid & cfg_ready.
  - If addr < 5: shadow[addr] <= cfg_data and mask[addr] <= 1.
  - Otherwise the write is dropped and err_addr is set.
- IDLE, commit:
  - cfg_commit clears err_incomplete, err_unstable, err_verify and forced; the next state is CHECK.
  - cfg_valid and cfg_commit in the same cycle: the write lands first, and CHECK evaluates the updated shadow.
- Mask lifetime: the mask is cleared only by reset, so partial updates are allowed after the first full load.
- CHECK (1 cycle), rejections:
  - mask != 5'b11111: set err_incomplete, pulse done, go to IDLE.
  - Unstable denominator: set err_unstable, pulse done, go to IDLE.
- Stability test:
  - Evaluated with a1, a2 sign-extended to COEFF_WIDTH+2 bits, with ONE = 2^COEFF_FRAC.
  - Stable iff -ONE < a2 < ONE and |a1| < ONE + a2. All comparisons are strict.
  - The extension avoids overflow when taking |a1| at the most negative value.
- CHECK pass: go to WAIT_GAP and clear the gap counter.
- WAIT_GAP, write issue:
  - coeff_wr_en is combinational: 1 when state==WAIT_GAP and (sample_valid==0 or counter==GAP_TIMEOUT-1).
  - In that cycle the next state is VERIFY. If the write is caused by the timeout (sample_valid still 1), set forced.
  - Otherwise the counter increments.
  - coeff_wr_en is never high for more than 1 cycle per commit.
- VERIFY (1 cycle, the cycle after the write edge):
  - If coeff_rb[i] != shadow[i] for any i, set err_verify.
  - Pulse done and go to IDLE.
- Latency (commit accepted at cycle N):
  - CHECK at N+1; earliest write at N+2; done at N+3.
  - Worst case: done at N+2+GAP_TIMEOUT.
- Stability to the write: shadow regs cannot change while busy, because cfg_ready=0 and writes/commits while busy are ignored.
- coeff_in always reflects the shadow registers.

Test Plan:
- Reset, then commit with no writes → err_incomplete=1 and done at N+2; coeff_wr_en never asserted.
- Write b0=0x37061, b1=0x5907C, b2=0x37061, a1=0x5907C, a2=0x2E0C3; commit with sample_valid=0 → coeff_wr_en for exactly 1 cycle at N+2, done at N+3, no errors, coeff_in matches the written values.
- Write a2=0x40000 (1.0), commit → err_unstable=1, no write. Then write a2=0x2E0C3 and a1=0x70000 (458752 > 450755) → err_unstable=1. Then write a1=0x5907C and commit → success.
- Hold sample_valid=1 continuously, commit → write at exactly N+2+63, forced=1, done next cycle. Repeat with sample_valid dropping at N+10 → write at N+10, forced=0.
- Write cfg_addr=6 → err_addr=1, shadow unchanged. With the bench model corrupting coeff_rb[3] → err_verify=1. Assert rst while in WAIT_GAP → coeff_wr_en=0, mask cleared, next commit gives err_incomplete.
- cfg_valid with cfg_addr=4 and cfg_commit in the same cycle → the new a2 value appears on coeff_in at the write cycle. cfg_valid asserted while busy → ignored, cfg_ready=0.
